// File: rtl/count15_pkg.sv
// Shared constants and state type for the counter sequence monitor.
package count15_pkg;

  localparam int Q_W_DEFAULT = 4;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; an increment
// arriving together with a clear leaves the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= inc_i ? W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count15_seq_monitor.sv
// Watches a free-running mod-2**Q_W counter, locks onto a clean +1 sequence,
// counts wraps and flags out-of-sequence samples once locked.
module count15_seq_monitor
  import count15_pkg::*;
#(
  parameter int Q_W      = Q_W_DEFAULT,
  parameter int LOCK_LEN = 4,
  parameter int WRAP_W   = 16,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Q_W-1:0]    q_in,
  input  logic              q_valid,
  input  logic              q_restart,
  input  logic              clr_err,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wraps,
  output logic              seq_err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count,
  output logic              state_dbg
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);

  mon_state_e       state_q;
  logic             have_prev_q;
  logic [Q_W-1:0]   prev_q;
  logic [RUN_W-1:0] run_q;
  logic             locked_q;
  logic             wrap_pulse_q;
  logic             seq_err_q;
  logic             err_sticky_q;

  logic [Q_W-1:0]   exp_val;
  logic [RUN_W-1:0] run_inc;
  logic             legal;
  logic             wrap_inc;
  logic             err_inc;

  always_comb begin
    exp_val  = q_restart ? '0 : prev_q + Q_W'(1);
    legal    = (have_prev_q && (q_in == exp_val)) || (q_restart && (q_in == '0));
    run_inc  = run_q + RUN_W'(1);
    wrap_inc = 1'b0;
    err_inc  = 1'b0;
    if (q_valid && (state_q == LOCKED)) begin
      // A restart to zero is legal but is not a natural wrap.
      wrap_inc = legal && !q_restart && (prev_q == '1) && (q_in == '0);
      err_inc  = !legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACQUIRE;
      have_prev_q  <= 1'b0;
      prev_q       <= '0;
      run_q        <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      seq_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      wrap_pulse_q <= wrap_inc;
      seq_err_q    <= err_inc;
      if (err_inc) begin
        err_sticky_q <= 1'b1;
      end else if (clr_err) begin
        err_sticky_q <= 1'b0;
      end
      if (q_valid) begin
        prev_q      <= q_in;
        have_prev_q <= 1'b1;
        case (state_q)
          ACQUIRE: begin
            if (legal) begin
              if (run_inc == RUN_W'(LOCK_LEN)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                run_q    <= '0;
              end else begin
                run_q <= run_inc;
              end
            end else if (have_prev_q) begin
              // The very first sample only seeds prev and never resets the run.
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (!legal) begin
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
              run_q    <= '0;
            end
          end
          default: begin
            state_q  <= ACQUIRE;
            locked_q <= 1'b0;
            run_q    <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(WRAP_W)) u_wraps (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (1'b0),
    .inc_i   (wrap_inc),
    .count_o (wraps)
  );

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (clr_err),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign seq_err    = seq_err_q;
  assign err_sticky = err_sticky_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_count15_seq_monitor.sv
// Directed bench for count15_seq_monitor: an abstract model checked every
// cycle plus hand-computed literal expectations at key points.
module tb_count15_seq_monitor;

  localparam int Q_W      = 4;
  localparam int MODULUS  = 16;
  localparam int LOCK_LEN = 4;
  localparam int WRAP_W   = 16;
  localparam int ERR_W    = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [Q_W-1:0]    q_in = '0;
  logic              q_valid = 1'b0;
  logic              q_restart = 1'b0;
  logic              clr_err = 1'b0;
  logic              locked;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wraps;
  logic              seq_err;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_count;
  logic              state_dbg;

  count15_seq_monitor #(
    .Q_W(Q_W), .LOCK_LEN(LOCK_LEN), .WRAP_W(WRAP_W), .ERR_W(ERR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .q_valid    (q_valid),
    .q_restart  (q_restart),
    .clr_err    (clr_err),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wraps      (wraps),
    .seq_err    (seq_err),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .state_dbg  (state_dbg)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // behavioural model: unbounded event counts, saturation applied on output
  bit m_have_prev, m_locked, m_wrap_p, m_err_p, m_sticky;
  int m_prev, m_run, m_wraps, m_errs;

  function automatic int sat(int v, int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick(bit rst, bit v, bit rs, bit clr, int q);
    int  expv;
    bit  legal;
    if (rst) begin
      m_have_prev = 0; m_locked = 0; m_wrap_p = 0; m_err_p = 0; m_sticky = 0;
      m_prev = 0; m_run = 0; m_wraps = 0; m_errs = 0;
      return;
    end
    m_wrap_p = 0;
    m_err_p  = 0;
    if (clr) begin
      m_sticky = 0;
      m_errs   = 0;
    end
    if (v) begin
      expv  = rs ? 0 : (m_prev + 1) % MODULUS;
      legal = (m_have_prev && q == expv) || (rs && q == 0);
      if (!m_locked) begin
        if (legal) m_run++;
        else if (m_have_prev) m_run = 0;
        if (m_run == LOCK_LEN) begin
          m_locked = 1;
          m_run    = 0;
        end
      end else if (legal) begin
        if (m_prev == MODULUS - 1 && q == 0 && !rs) begin
          m_wrap_p = 1;
          m_wraps++;
        end
      end else begin
        m_err_p  = 1;
        m_sticky = 1;
        m_errs++;
        m_locked = 0;
        m_run    = 0;
      end
      m_prev      = q;
      m_have_prev = 1;
    end
  endtask

  // driver tasks
  task automatic step(bit rst, bit v, bit rs, bit clr, int q);
    reset     = rst;
    q_valid   = v;
    q_restart = rs;
    clr_err   = clr;
    q_in      = Q_W'(q);
    @(posedge clk);
    model_tick(rst, v, rs, clr, q);
    #1;
  endtask

  task automatic stepv(int q);
    step(0, 1, 0, 0, q);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic legal_steps(int n);
    for (int i = 0; i < n; i++) stepv((m_prev + 1) % MODULUS);
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",     int'(locked),     int'(m_locked));
      check("state_dbg",  int'(state_dbg),  int'(m_locked));
      check("wrap_pulse", int'(wrap_pulse), int'(m_wrap_p));
      check("wraps",      int'(wraps),      sat(m_wraps, WRAP_W));
      check("seq_err",    int'(seq_err),    int'(m_err_p));
      check("err_sticky", int'(err_sticky), int'(m_sticky));
      check("err_count",  int'(err_count),  sat(m_errs, ERR_W));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 5);
    chk_en = 1'b1;
    check("reset_locked", int'(locked), 0);
    check("reset_wraps", int'(wraps), 0);

    // 1: acquire on 0..4
    for (int i = 0; i <= 4; i++) begin
      stepv(i);
      if (i == 3) check("t1_not_yet_locked", int'(locked), 0);
    end
    check("t1_locked", int'(locked), 1);
    check("t1_no_err", int'(seq_err), 0);

    // 2: wraps
    for (int i = 5; i <= 15; i++) stepv(i);
    stepv(0);
    check("t2_wrap_pulse", int'(wrap_pulse), 1);
    check("t2_wraps1", int'(wraps), 1);
    stepv(1);
    check("t2_pulse_drop", int'(wrap_pulse), 0);
    legal_steps(320);
    check("t2_wraps21", int'(wraps), 21);

    // 3: out-of-sequence and relock
    for (int i = 2; i <= 6; i++) stepv(i);
    stepv(9);
    check("t3_seq_err", int'(seq_err), 1);
    check("t3_sticky", int'(err_sticky), 1);
    check("t3_err_count", int'(err_count), 1);
    check("t3_unlocked", int'(locked), 0);
    stepv(10); stepv(11); stepv(12);
    check("t3_still_acq", int'(locked), 0);
    stepv(13);
    check("t3_relocked", int'(locked), 1);
    stepv(14);
    check("t3_err_drop", int'(seq_err), 0);

    // 4: restart handling
    stepv(15);
    for (int i = 0; i <= 7; i++) stepv(i);
    check("t4_wraps22", int'(wraps), 22);
    step(0, 1, 1, 0, 0);
    check("t4_restart_no_err", int'(seq_err), 0);
    check("t4_restart_no_wrap", int'(wrap_pulse), 0);
    check("t4_restart_locked", int'(locked), 1);
    step(0, 1, 1, 0, 3);
    check("t4_bad_restart_err", int'(seq_err), 1);
    check("t4_err_count2", int'(err_count), 2);

    // 5: err_count saturation and clear collision
    for (int k = 0; k < 3; k++) begin
      legal_steps(4);
      stepv((m_prev + 5) % MODULUS);
    end
    check("t5_err_sat", int'(err_count), 3);
    legal_steps(4);
    step(0, 1, 0, 1, (m_prev + 5) % MODULUS);
    check("t5_clr_vs_err_count", int'(err_count), 1);
    check("t5_clr_vs_err_sticky", int'(err_sticky), 1);
    step(0, 0, 0, 1, 0);
    check("t5_clr_count", int'(err_count), 0);
    check("t5_clr_sticky", int'(err_sticky), 0);

    // 6: reset mid-lock, then gaps while locking
    legal_steps(4);
    check("t6_locked_pre", int'(locked), 1);
    step(1, 1, 0, 0, 3);
    check("t6_rst_locked", int'(locked), 0);
    check("t6_rst_wraps", int'(wraps), 0);
    check("t6_rst_err_count", int'(err_count), 0);
    check("t6_rst_sticky", int'(err_sticky), 0);
    stepv(0); stepv(1); idle(); stepv(2); idle(); idle(); stepv(3);
    check("t6_gap_not_locked", int'(locked), 0);
    stepv(4);
    check("t6_gap_locked", int'(locked), 1);
    idle(); idle(); idle();
    stepv(5);
    check("t6_gap_keeps_lock", int'(locked), 1);
    check("t6_gap_no_err", int'(seq_err), 0);
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
